// File: rtl/ysyx_22050039_exctl_pkg.sv
// Shared definitions for the execute-stage controller: op encodings, op classes,
// FSM states, trap codes and MDU operation codes.
package ysyx_22050039_exctl_pkg;

    localparam int FUNC_LEN = 5;
    localparam int MDU_OP_W = 3;

    localparam logic [FUNC_LEN-1:0] FN_ADD    = 5'd1;
    localparam logic [FUNC_LEN-1:0] FN_ADDI   = 5'd2;
    localparam logic [FUNC_LEN-1:0] FN_SUB    = 5'd3;
    localparam logic [FUNC_LEN-1:0] FN_AND    = 5'd4;
    localparam logic [FUNC_LEN-1:0] FN_OR     = 5'd5;
    localparam logic [FUNC_LEN-1:0] FN_XOR    = 5'd6;
    localparam logic [FUNC_LEN-1:0] FN_SLL    = 5'd7;
    localparam logic [FUNC_LEN-1:0] FN_SRL    = 5'd8;
    localparam logic [FUNC_LEN-1:0] FN_LUI    = 5'd9;
    localparam logic [FUNC_LEN-1:0] FN_AUIPC  = 5'd10;
    localparam logic [FUNC_LEN-1:0] FN_JAL    = 5'd11;
    localparam logic [FUNC_LEN-1:0] FN_JALR   = 5'd12;
    localparam logic [FUNC_LEN-1:0] FN_MUL    = 5'd16;
    localparam logic [FUNC_LEN-1:0] FN_MULH   = 5'd17;
    localparam logic [FUNC_LEN-1:0] FN_DIV    = 5'd18;
    localparam logic [FUNC_LEN-1:0] FN_DIVU   = 5'd19;
    localparam logic [FUNC_LEN-1:0] FN_REM    = 5'd20;
    localparam logic [FUNC_LEN-1:0] FN_REMU   = 5'd21;
    localparam logic [FUNC_LEN-1:0] FN_EBREAK = 5'd31;

    typedef enum logic [2:0] {
        CLS_SINGLE,
        CLS_MDU,
        CLS_JUMP,
        CLS_EBREAK,
        CLS_INVALID
    } opclass_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MDU,
        ST_DONE,
        ST_HALT
    } state_e;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_EBREAK  = 2'd1;
    localparam logic [1:0] TRAP_INVALID = 2'd2;
    localparam logic [1:0] TRAP_TIMEOUT = 2'd3;

    localparam logic [MDU_OP_W-1:0] MDU_MUL  = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULH = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_DIV  = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_REM  = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_REMU = 3'd7;

endpackage

// File: rtl/ysyx_22050039_exctl_if.sv
// Exctl bus: decode handshake, EXU/MDU side channels and writeback handshake.
// slave = controller side, master = surrounding pipeline / environment.
interface ysyx_22050039_exctl_if #(
    parameter int XLEN = 64
);
    import ysyx_22050039_exctl_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [FUNC_LEN-1:0] in_func;
    logic [XLEN-1:0]     in_src1;
    logic [XLEN-1:0]     in_src2;
    logic [XLEN-1:0]     in_pc;
    logic [4:0]          in_rd;

    logic [FUNC_LEN-1:0] exu_func;
    logic [XLEN-1:0]     exu_src1;
    logic [XLEN-1:0]     exu_src2;
    logic [XLEN-1:0]     exu_pc;
    logic [XLEN-1:0]     exu_result;
    logic [XLEN-1:0]     exu_dnpc;

    logic                mdu_start;
    logic [MDU_OP_W-1:0] mdu_op;
    logic                mdu_done;
    logic [XLEN-1:0]     mdu_result;

    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_result;
    logic [XLEN-1:0]     out_dnpc;
    logic [4:0]          out_rd;
    logic                out_jump;
    logic                halt;
    logic [1:0]          trap_code;

    modport slave (
        input  in_valid, in_func, in_src1, in_src2, in_pc, in_rd,
        input  exu_result, exu_dnpc, mdu_done, mdu_result, out_ready,
        output in_ready, exu_func, exu_src1, exu_src2, exu_pc,
        output mdu_start, mdu_op,
        output out_valid, out_result, out_dnpc, out_rd, out_jump, halt, trap_code
    );

    modport master (
        output in_valid, in_func, in_src1, in_src2, in_pc, in_rd,
        output exu_result, exu_dnpc, mdu_done, mdu_result, out_ready,
        input  in_ready, exu_func, exu_src1, exu_src2, exu_pc,
        input  mdu_start, mdu_op,
        input  out_valid, out_result, out_dnpc, out_rd, out_jump, halt, trap_code
    );

endinterface

// File: rtl/ysyx_22050039_opclass.sv
// Op-class decoder: func -> single/mdu/jump/ebreak/invalid plus MDU op code.
// Mul/div funcs decode as MDU only when YSYX_22050039_MULDIV_EN is defined.
module ysyx_22050039_opclass
    import ysyx_22050039_exctl_pkg::*;
(
    input  logic [FUNC_LEN-1:0] func_i,
    output opclass_e            cls_o,
    output logic [MDU_OP_W-1:0] mdu_op_o
);

    always_comb begin
        cls_o    = CLS_INVALID;
        mdu_op_o = MDU_MUL;
        case (func_i)
            FN_ADD, FN_ADDI, FN_SUB, FN_AND, FN_OR, FN_XOR,
            FN_SLL, FN_SRL, FN_LUI, FN_AUIPC: cls_o = CLS_SINGLE;
            FN_JAL, FN_JALR:                  cls_o = CLS_JUMP;
            FN_EBREAK:                        cls_o = CLS_EBREAK;
`ifdef YSYX_22050039_MULDIV_EN
            FN_MUL:  begin cls_o = CLS_MDU; mdu_op_o = MDU_MUL;  end
            FN_MULH: begin cls_o = CLS_MDU; mdu_op_o = MDU_MULH; end
            FN_DIV:  begin cls_o = CLS_MDU; mdu_op_o = MDU_DIV;  end
            FN_DIVU: begin cls_o = CLS_MDU; mdu_op_o = MDU_DIVU; end
            FN_REM:  begin cls_o = CLS_MDU; mdu_op_o = MDU_REM;  end
            FN_REMU: begin cls_o = CLS_MDU; mdu_op_o = MDU_REMU; end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_22050039_exctl.sv
// Execute-stage controller: accepts decoded ops, sequences EXU / MDU, delivers writeback.
// Optional MDU path enabled by YSYX_22050039_MULDIV_EN (otherwise mul/div trap as invalid).
module ysyx_22050039_exctl
    import ysyx_22050039_exctl_pkg::*;
#(
    parameter int XLEN        = 64,
    parameter int MDU_TIMEOUT = 127
) (
    input logic                  clk,
    input logic                  rst,
    ysyx_22050039_exctl_if.slave bus
);

    state_e              state_q;
    logic [FUNC_LEN-1:0] func_q;
    logic [XLEN-1:0]     src1_q, src2_q, pc_q;
    logic [4:0]          rd_q;
    logic                jump_q;

    logic                out_valid_q, out_jump_q, halt_q;
    logic [XLEN-1:0]     out_result_q, out_dnpc_q;
    logic [4:0]          out_rd_q;
    logic [1:0]          trap_q;

    opclass_e            dec_cls;
    logic [MDU_OP_W-1:0] dec_mdu_op;
    state_e              disp_state;
    logic [1:0]          disp_trap;
    logic                in_ready;
    logic                accept;

    ysyx_22050039_opclass u_opclass (
        .func_i   (bus.in_func),
        .cls_o    (dec_cls),
        .mdu_op_o (dec_mdu_op)
    );

    // Ready in DONE depends on out_ready so a new op can enter in the transfer cycle.
    assign in_ready = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready));
    assign accept   = bus.in_valid & in_ready;

    always_comb begin
        disp_state = ST_EXEC;
        disp_trap  = TRAP_INVALID;
        case (dec_cls)
            CLS_EBREAK: begin
                disp_state = ST_HALT;
                disp_trap  = TRAP_EBREAK;
            end
            CLS_INVALID: disp_state = ST_HALT;
`ifdef YSYX_22050039_MULDIV_EN
            CLS_MDU:     disp_state = ST_MDU;
`endif
            default: ;
        endcase
    end

`ifdef YSYX_22050039_MULDIV_EN
    localparam int WD_W = $clog2(MDU_TIMEOUT + 1);
    logic                mdu_start_q;
    logic [MDU_OP_W-1:0] mdu_op_q;
    logic [WD_W-1:0]     wdog_q;

    assign bus.mdu_start = mdu_start_q;
    assign bus.mdu_op    = mdu_op_q;
`else
    logic unused_mdu;
    assign unused_mdu    = ^{bus.mdu_done, bus.mdu_result, dec_mdu_op, 32'(MDU_TIMEOUT)};
    assign bus.mdu_start = 1'b0;
    assign bus.mdu_op    = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            func_q       <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            pc_q         <= '0;
            rd_q         <= '0;
            jump_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_dnpc_q   <= '0;
            out_rd_q     <= '0;
            out_jump_q   <= 1'b0;
            halt_q       <= 1'b0;
            trap_q       <= TRAP_NONE;
`ifdef YSYX_22050039_MULDIV_EN
            mdu_start_q  <= 1'b0;
            mdu_op_q     <= '0;
            wdog_q       <= '0;
`endif
        end else begin
`ifdef YSYX_22050039_MULDIV_EN
            mdu_start_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: ;
                ST_EXEC: begin
                    out_valid_q  <= 1'b1;
                    out_result_q <= bus.exu_result;
                    out_dnpc_q   <= jump_q ? bus.exu_dnpc : '0;
                    out_jump_q   <= jump_q;
                    out_rd_q     <= rd_q;
                    state_q      <= ST_DONE;
                end
`ifdef YSYX_22050039_MULDIV_EN
                // Done is checked first so it wins over a simultaneous timeout.
                ST_MDU: begin
                    if (bus.mdu_done) begin
                        out_valid_q  <= 1'b1;
                        out_result_q <= bus.mdu_result;
                        out_dnpc_q   <= '0;
                        out_jump_q   <= 1'b0;
                        out_rd_q     <= rd_q;
                        state_q      <= ST_DONE;
                    end else if (wdog_q == WD_W'(MDU_TIMEOUT - 1)) begin
                        halt_q  <= 1'b1;
                        trap_q  <= TRAP_TIMEOUT;
                        state_q <= ST_HALT;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
`endif
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_HALT: ;
                default: state_q <= ST_IDLE;
            endcase

            // Accept overrides the transition above (covers the DONE back-to-back case).
            if (accept) begin
                func_q  <= bus.in_func;
                src1_q  <= bus.in_src1;
                src2_q  <= bus.in_src2;
                pc_q    <= bus.in_pc;
                rd_q    <= bus.in_rd;
                jump_q  <= (dec_cls == CLS_JUMP);
                state_q <= disp_state;
                if (disp_state == ST_HALT) begin
                    halt_q <= 1'b1;
                    trap_q <= disp_trap;
                end
`ifdef YSYX_22050039_MULDIV_EN
                if (disp_state == ST_MDU) begin
                    mdu_start_q <= 1'b1;
                    mdu_op_q    <= dec_mdu_op;
                    wdog_q      <= '0;
                end
`endif
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.exu_func   = func_q;
    assign bus.exu_src1   = src1_q;
    assign bus.exu_src2   = src2_q;
    assign bus.exu_pc     = pc_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_dnpc   = out_dnpc_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_jump   = out_jump_q;
    assign bus.halt       = halt_q;
    assign bus.trap_code  = trap_q;

endmodule

// File: doc/ysyx_22050039_exctl.md
YSYX_22050039_EXCTL -- requirements
Module: ysyx_22050039_exctl

Interface
REQ-001 Parameters: XLEN, 64, datapath width; FUNC_LEN, package constant, width of the op code; MDU_TIMEOUT, 127, maximum cycles to wait for MDU done.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid/in_ready  in/out  1/1  decode-side handshake.
- in_func  in  FUNC_LEN  decoded op.
- in_src1, in_src2, in_pc  in  XLEN  operands and pc.
- in_rd  in  5  destination register index.
- exu_func/exu_src1/exu_src2/exu_pc  out  FUNC_LEN/XLEN  latched op driven to the combinational EXU.
- exu_result, exu_dnpc  in  XLEN  EXU outputs.
- mdu_start  out  1  one-cycle start pulse.
- mdu_op  out  3  MDU operation.
- mdu_done  in  1  MDU result valid.
- mdu_result  in  XLEN  MDU result.
- out_valid/out_ready  out/in  1/1  writeback handshake.
- out_result, out_dnpc  out  XLEN  result and next pc.
- out_rd  out  5  destination register index.
- out_jump  out  1  out_dnpc is valid.
- halt  out  1  sticky stop.
- trap_code  out  2  0 none, 1 ebreak, 2 invalid op, 3 MDU timeout.

Function
REQ-003 FSM states: IDLE, EXEC, MDU, DONE, HALT.
REQ-004 in_ready SHALL be 1 in IDLE, and in DONE when out_ready=1; it is 0 otherwise.
REQ-005 On accept (in_valid & in_ready), func/src1/src2/pc/rd SHALL be latched.
- Next state is EXEC for single-cycle ops.
- Next state is MDU for mul/div ops.
- Next state is HALT for Ebreak or an unrecognised func.
REQ-006 EXEC SHALL last exactly one cycle: capture exu_result and exu_dnpc, then go to DONE. out_valid rises 2 cycles after accept.
REQ-007 out_jump SHALL be 1 only for Jal and Jalr. out_dnpc SHALL be 0 when out_jump=0.
REQ-008 On entry to MDU: mdu_start SHALL pulse for exactly one cycle; mdu_op is held stable until done.
- A watchdog counter is cleared on entry and increments each cycle.
- mdu_done captures mdu_result and moves to DONE.
- Counter reaching MDU_TIMEOUT with no done moves to HALT with trap_code=3.
REQ-009 mdu_done and counter==MDU_TIMEOUT in the same cycle: done SHALL win.
REQ-010 DONE SHALL hold out_valid=1 and stable out_* until out_ready=1.
- out_ready=1 with in_valid=0: transfer, go to IDLE.
- out_ready=1 with in_valid=1: transfer and accept the new op in the same cycle (back-to-back, no bubble).
REQ-011 HALT SHALL be absorbing until rst.
- halt=1, in_ready=0, out_valid=0, trap_code held.
- Ebreak and invalid SHALL NOT produce out_valid.
REQ-012 mdu_done outside the MDU state SHALL be ignored.
REQ-013 No result is dropped or duplicated: exactly one out_valid&out_ready transfer per accepted non-trapping op.

Reset
REQ-014 rst SHALL force the following on the next edge, regardless of current state (including mid-MDU):
- state IDLE;
- out_valid=0, mdu_start=0, halt=0, trap_code=0;
- out_result/out_dnpc/out_rd/out_jump=0;
- latched op and watchdog cleared.
REQ-015 While rst=1: in_ready=0.
REQ-016 A late mdu_done after reset SHALL be ignored, per REQ-012.

Configuration
REQ-017 Macro YSYX_22050039_MULDIV_EN:
- Defined: mul/div funcs route to the MDU path.
- Undefined: mul/div funcs are treated as invalid (HALT, trap_code=2); mdu_start is tied 0; the watchdog is not built.

Structure
REQ-018 The shared package SHALL hold:
- func encodings and FUNC_LEN;
- op-class decode constants;
- the FSM state enum;
- trap_code values;
- mdu_op encodings.
REQ-019 The op-class decoder SHALL be a separate sub-module, ysyx_22050039_opclass (func -> single/mdu/jump/ebreak/invalid). The FSM, watchdog and output registers stay in this block.

Verification
REQ-020 Addi, src1=5, src2=7, out_ready=1 -> out_valid 2 cycles after accept, out_result=12, out_jump=0.
REQ-021 Jal, pc=0x80000000, src1=0x10 -> out_result=0x80000004, out_dnpc=0x80000010, out_jump=1.
REQ-022 Two back-to-back Addi ops, out_ready held 0 for 3 cycles then 1 -> first result stable across the stall; second accepted in the transfer cycle; both delivered in order.
REQ-023 MULDIV_EN defined, mul op, mdu_done after 10 cycles with 0x2A -> single mdu_start pulse, out_result=0x2A.
REQ-024 MULDIV_EN defined, mdu_done never asserted -> halt=1, trap_code=3 at cycle MDU_TIMEOUT after entry.
REQ-025 Ebreak -> halt=1, trap_code=1, no out_valid. Then rst for one cycle mid-HALT -> all outputs 0 and in_ready=1 the cycle after rst deasserts.
